k_sequencer: RTL and testbench
==============================

# k_sequencer

Parametrised, clocked SHA-2 round-constant sequencer. It replaces per-round combinational K lookup in the compression datapath. On `start` it streams K[0]..K[ROUNDS-1] in order over a valid/ready handshake, one constant per accepted beat, then pulses `done`. A single parameter selects the SHA-224/256 table (64 × 32-bit) or the SHA-384/512 table (80 × 64-bit), so both compression cores share one block.

## Interface
- `VARIANT`, default 256. Either 256 (32-bit words, 64 rounds, FIPS 180-4 §4.2.2) or 512 (64-bit words, 80 rounds, §4.2.3). Any other value is an elaboration error.
- `WORD_W`, derived. 32 when VARIANT=256, 64 when VARIANT=512.
- `ROUNDS`, derived. 64 when VARIANT=256, 80 when VARIANT=512.
- `RND_W`, derived. 6 when VARIANT=256, 7 when VARIANT=512.

Ports:
- `clk`  in  1  Single clock. All state changes on the rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `start`  in  1  Request a new constant stream. Sampled only in IDLE.
- `abort`  in  1  Terminate the stream at once and return to IDLE.
- `k_ready`  in  1  Consumer accepts the current beat.
- `k_valid`  out  1  `k_out` and `round_n` hold a valid constant.
- `k_out`  out  WORD_W  K[round_n], registered.
- `round_n`  out  RND_W  Index of the constant on `k_out`.
- `k_last`  out  1  High with the beat where round_n = ROUNDS-1.
- `busy`  out  1  High while in RUN.
- `done`  out  1  One-cycle pulse after the last beat is accepted.

## Operation
- Two states, IDLE and RUN. The state register resets to IDLE.
- In IDLE, `start`=1 and `abort`=0 move the block to RUN. On the next edge it loads round_n=0 and k_out=K[0], and asserts k_valid and busy.
- In RUN, a beat is accepted on an edge where k_valid=1 and k_ready=1.
  - For an accepted beat with round_n<ROUNDS-1: round_n increments and k_out is loaded with K[round_n+1] on that edge.
  - For an accepted beat with round_n=ROUNDS-1: go to IDLE. k_valid, k_last and busy go to 0, done=1 for one cycle, and round_n and k_out clear to 0.
- While k_ready=0 in RUN, k_out, round_n and k_last hold.
- k_last is registered: k_last = k_valid && (round_n == ROUNDS-1).
- `abort`=1 in any state goes to IDLE on the next edge. Outputs take reset values and no done pulse is issued.
- `start` is ignored while in RUN. It is not queued.
- Constant table: a case ROM indexed by the next round index. Values come from FIPS 180-4. Indices ≥ ROUNDS are never addressed, and their default value is 0.
- round_n never wraps. It saturates logically at ROUNDS-1 because the last acceptance leaves RUN.

## Timing
- Reset values of all outputs are 0: k_valid, k_out, round_n, k_last, busy, done.
- start→first beat: 1 cycle. If start is sampled at edge N, then k_valid=1 with K[0] after edge N.
- Throughput: 1 constant/cycle with k_ready held high. A full stream takes ROUNDS cycles. With start pulsed in the done cycle, back-to-back streams run at ROUNDS+1 cycles per block.
- done is high during the cycle after the final acceptance. The state is IDLE in that cycle, so a start asserted then is accepted.
- Simultaneous-event priority is rst > abort > start/handshake:
  - abort and a final acceptance in the same cycle: no done.
  - abort and start in IDLE: the block stays in IDLE.
- rst mid-stream: all outputs are 0 on the next edge and state is IDLE. The next stream restarts from K[0].
- No combinational path from any input to any output. All outputs are flops.

## Test plan
- VARIANT=256, rst released, start pulse, k_ready=1 constantly:
  - k_out=32'h428a2f98 with round_n=0 one cycle after start, then K[1]=32'h71374491.
  - round_n=63 gives 32'hc67178f2 with k_last=1.
  - done=1 exactly 64 cycles after the first valid beat.
- VARIANT=512, same stimulus:
  - round 0 = 64'h428a2f98d728ae22.
  - round 79 = 64'h6c44198c4a475817 with k_last=1.
  - done after 80 beats. Compare all 80 values against the FIPS table.
- Backpressure: k_ready=0 for 5 cycles at round_n=10 (VARIANT=256) → k_out stays 32'h243185be and round_n stays 10. The stream resumes with 32'h550c7dc3 when k_ready returns to 1.
- abort at round_n=30 → k_valid=0, busy=0 and round_n=0 on the next cycle, with no done. A following start gives K[0] again.
- start asserted continuously from reset → streams repeat. Each done cycle is followed by round 0 one cycle later. start pulses mid-RUN do not disturb round_n.
- rst asserted at round_n=40 together with k_ready=1 → all outputs are 0 on the next cycle. No done pulse, and state is IDLE.

Source files
------------

// File: rtl/k_sequencer.sv
// SHA-2 round-constant sequencer: streams K[0..ROUNDS-1] over valid/ready, then pulses done.
// One 80 x 64-bit table serves both variants; SHA-256 K[i] is the upper half of SHA-512 K[i].
module k_sequencer #(
  parameter int VARIANT = 256,
  localparam int WORD_W = (VARIANT == 512) ? 64 : 32,
  localparam int ROUNDS = (VARIANT == 512) ? 80 : 64,
  localparam int RND_W  = (VARIANT == 512) ? 7 : 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              k_ready,
  output logic              k_valid,
  output logic [WORD_W-1:0] k_out,
  output logic [RND_W-1:0]  round_n,
  output logic              k_last,
  output logic              busy,
  output logic              done
);

  if (VARIANT != 256 && VARIANT != 512) begin : g_bad_variant
    $error("k_sequencer: VARIANT must be 256 or 512");
  end

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state, w_state_next;
  logic               r_valid, w_valid_next;
  logic [RND_W-1:0]   r_round, w_round_next;
  logic [WORD_W-1:0]  r_k, w_k_next;
  logic               r_last, w_last_next;
  logic               r_busy, w_busy_next;
  logic               r_done, w_done_next;
  logic [6:0]         w_rom_idx;
  logic [WORD_W-1:0]  w_k_rom;
  logic               w_accept;
  logic               w_final;

  function automatic logic [WORD_W-1:0] k_rom(input logic [6:0] idx);
    logic [63:0] v;
    case (idx)
      7'd0:  v = 64'h428a2f98d728ae22;  7'd1:  v = 64'h7137449123ef65cd;
      7'd2:  v = 64'hb5c0fbcfec4d3b2f;  7'd3:  v = 64'he9b5dba58189dbbc;
      7'd4:  v = 64'h3956c25bf348b538;  7'd5:  v = 64'h59f111f1b605d019;
      7'd6:  v = 64'h923f82a4af194f9b;  7'd7:  v = 64'hab1c5ed5da6d8118;
      7'd8:  v = 64'hd807aa98a3030242;  7'd9:  v = 64'h12835b0145706fbe;
      7'd10: v = 64'h243185be4ee4b28c;  7'd11: v = 64'h550c7dc3d5ffb4e2;
      7'd12: v = 64'h72be5d74f27b896f;  7'd13: v = 64'h80deb1fe3b1696b1;
      7'd14: v = 64'h9bdc06a725c71235;  7'd15: v = 64'hc19bf174cf692694;
      7'd16: v = 64'he49b69c19ef14ad2;  7'd17: v = 64'hefbe4786384f25e3;
      7'd18: v = 64'h0fc19dc68b8cd5b5;  7'd19: v = 64'h240ca1cc77ac9c65;
      7'd20: v = 64'h2de92c6f592b0275;  7'd21: v = 64'h4a7484aa6ea6e483;
      7'd22: v = 64'h5cb0a9dcbd41fbd4;  7'd23: v = 64'h76f988da831153b5;
      7'd24: v = 64'h983e5152ee66dfab;  7'd25: v = 64'ha831c66d2db43210;
      7'd26: v = 64'hb00327c898fb213f;  7'd27: v = 64'hbf597fc7beef0ee4;
      7'd28: v = 64'hc6e00bf33da88fc2;  7'd29: v = 64'hd5a79147930aa725;
      7'd30: v = 64'h06ca6351e003826f;  7'd31: v = 64'h142929670a0e6e70;
      7'd32: v = 64'h27b70a8546d22ffc;  7'd33: v = 64'h2e1b21385c26c926;
      7'd34: v = 64'h4d2c6dfc5ac42aed;  7'd35: v = 64'h53380d139d95b3df;
      7'd36: v = 64'h650a73548baf63de;  7'd37: v = 64'h766a0abb3c77b2a8;
      7'd38: v = 64'h81c2c92e47edaee6;  7'd39: v = 64'h92722c851482353b;
      7'd40: v = 64'ha2bfe8a14cf10364;  7'd41: v = 64'ha81a664bbc423001;
      7'd42: v = 64'hc24b8b70d0f89791;  7'd43: v = 64'hc76c51a30654be30;
      7'd44: v = 64'hd192e819d6ef5218;  7'd45: v = 64'hd69906245565a910;
      7'd46: v = 64'hf40e35855771202a;  7'd47: v = 64'h106aa07032bbd1b8;
      7'd48: v = 64'h19a4c116b8d2d0c8;  7'd49: v = 64'h1e376c085141ab53;
      7'd50: v = 64'h2748774cdf8eeb99;  7'd51: v = 64'h34b0bcb5e19b48a8;
      7'd52: v = 64'h391c0cb3c5c95a63;  7'd53: v = 64'h4ed8aa4ae3418acb;
      7'd54: v = 64'h5b9cca4f7763e373;  7'd55: v = 64'h682e6ff3d6b2b8a3;
      7'd56: v = 64'h748f82ee5defb2fc;  7'd57: v = 64'h78a5636f43172f60;
      7'd58: v = 64'h84c87814a1f0ab72;  7'd59: v = 64'h8cc702081a6439ec;
      7'd60: v = 64'h90befffa23631e28;  7'd61: v = 64'ha4506cebde82bde9;
      7'd62: v = 64'hbef9a3f7b2c67915;  7'd63: v = 64'hc67178f2e372532b;
      7'd64: v = 64'hca273eceea26619c;  7'd65: v = 64'hd186b8c721c0c207;
      7'd66: v = 64'heada7dd6cde0eb1e;  7'd67: v = 64'hf57d4f7fee6ed178;
      7'd68: v = 64'h06f067aa72176fba;  7'd69: v = 64'h0a637dc5a2c898a6;
      7'd70: v = 64'h113f9804bef90dae;  7'd71: v = 64'h1b710b35131c471b;
      7'd72: v = 64'h28db77f523047d84;  7'd73: v = 64'h32caab7b40c72493;
      7'd74: v = 64'h3c9ebe0a15c9bebc;  7'd75: v = 64'h431d67c49c100d4c;
      7'd76: v = 64'h4cc5d4becb3e42b6;  7'd77: v = 64'h597f299cfc657e2a;
      7'd78: v = 64'h5fcb6fab3ad6faec;  7'd79: v = 64'h6c44198c4a475817;
      default: v = '0;
    endcase
    return WORD_W'(v >> (64 - WORD_W));
  endfunction

  // ROM is addressed by the index that will be on round_n after this edge.
  assign w_rom_idx = (r_state == S_RUN) ? 7'(r_round + 1'b1) : 7'd0;
  assign w_k_rom   = (w_rom_idx < 7'(ROUNDS)) ? k_rom(w_rom_idx) : '0;
  assign w_accept  = r_valid && k_ready;
  assign w_final   = (r_round == RND_W'(ROUNDS - 1));

  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_valid;
    w_round_next = r_round;
    w_k_next     = r_k;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_RUN;
          w_valid_next = 1'b1;
          w_busy_next  = 1'b1;
          w_round_next = '0;
          w_k_next     = w_k_rom;
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (w_final) begin
            w_state_next = S_IDLE;
            w_valid_next = 1'b0;
            w_busy_next  = 1'b0;
            w_round_next = '0;
            w_k_next     = '0;
            w_done_next  = 1'b1;
          end else begin
            w_round_next = r_round + 1'b1;
            w_k_next     = w_k_rom;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // abort outranks both start and a final acceptance, and suppresses done.
    if (abort) begin
      w_state_next = S_IDLE;
      w_valid_next = 1'b0;
      w_busy_next  = 1'b0;
      w_round_next = '0;
      w_k_next     = '0;
      w_done_next  = 1'b0;
    end
  end

  assign w_last_next = w_valid_next && (w_round_next == RND_W'(ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_round <= '0;
      r_k     <= '0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_valid <= w_valid_next;
      r_round <= w_round_next;
      r_k     <= w_k_next;
      r_last  <= w_last_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign k_valid = r_valid;
  assign k_out   = r_k;
  assign round_n = r_round;
  assign k_last  = r_last;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_k_sequencer.sv
// Bench for k_sequencer: both variants share stimulus; a per-variant queue holds expected beats.
module tb_k_sequencer;

  logic clk = 1'b0;
  logic rst, start, abort, k_ready;
  logic v256, last256, busy256, done256;
  logic [31:0] k256;
  logic [5:0]  r256;
  logic v512, last512, busy512, done512;
  logic [63:0] k512;
  logic [6:0]  r512;

  k_sequencer #(.VARIANT(256)) u_dut256 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .k_ready(k_ready),
    .k_valid(v256), .k_out(k256), .round_n(r256), .k_last(last256),
    .busy(busy256), .done(done256)
  );

  k_sequencer #(.VARIANT(512)) u_dut512 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .k_ready(k_ready),
    .k_valid(v512), .k_out(k512), .round_n(r512), .k_last(last512),
    .busy(busy512), .done(done512)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          rnd;
    logic [63:0] k;
  } beat_t;

  beat_t q256[$];
  beat_t q512[$];
  logic [63:0] K [80];
  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clean();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    q256.delete();
    q512.delete();
  endtask

  task automatic push_stream(input bit is512);
    for (int i = 0; i < (is512 ? 80 : 64); i++) begin
      if (is512) q512.push_back('{i, K[i]});
      else       q256.push_back('{i, {K[i][63:32], 32'h0}});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; k_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({v256, k256, r256, last256, busy256, done256} !== '0) begin
      failures++;
      $display("FAIL reset256: v=%b k=%h r=%0d last=%b busy=%b done=%b, want all 0",
               v256, k256, r256, last256, busy256, done256);
    end
    checks++;
    if ({v512, k512, r512, last512, busy512, done512} !== '0) begin
      failures++;
      $display("FAIL reset512: v=%b k=%h r=%0d last=%b busy=%b done=%b, want all 0",
               v512, k512, r512, last512, busy512, done512);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({v256, busy256, done256, v512, busy512, done512} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: v256=%b v512=%b busy=%b/%b done=%b/%b, want 0",
               v256, v512, busy256, busy512, done256, done512);
    end
    $display("test_reset complete");
  endtask

  task automatic test_full_stream();
    beat_t e;
    int first256 = -1, first512 = -1, dat256 = -1, dat512 = -1, dn256 = 0, dn512 = 0;
    clean();
    push_stream(0);
    push_stream(1);
    start = 1'b1; k_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 120 && (dat256 < 0 || dat512 < 0); c++) begin
      if (v256) begin
        if (first256 < 0) first256 = c;
        checks++;
        if (q256.size() == 0) begin
          failures++;
          $display("FAIL stream256_extra: beat r=%0d k=%h, want no beat", r256, k256);
        end else begin
          e = q256.pop_front();
          if (k256 !== e.k[63:32] || r256 !== 6'(e.rnd) || last256 !== (e.rnd == 63) || busy256 !== 1'b1) begin
            failures++;
            $display("FAIL stream256_beat: k=%h r=%0d last=%b busy=%b, want k=%h r=%0d last=%b busy=1",
                     k256, r256, last256, busy256, e.k[63:32], e.rnd, e.rnd == 63);
          end
        end
      end
      if (v512) begin
        if (first512 < 0) first512 = c;
        checks++;
        if (q512.size() == 0) begin
          failures++;
          $display("FAIL stream512_extra: beat r=%0d k=%h, want no beat", r512, k512);
        end else begin
          e = q512.pop_front();
          if (k512 !== e.k || r512 !== 7'(e.rnd) || last512 !== (e.rnd == 79) || busy512 !== 1'b1) begin
            failures++;
            $display("FAIL stream512_beat: k=%h r=%0d last=%b busy=%b, want k=%h r=%0d last=%b busy=1",
                     k512, r512, last512, busy512, e.k, e.rnd, e.rnd == 79);
          end
        end
      end
      if (done256) begin dn256++; if (dat256 < 0) dat256 = c; end
      if (done512) begin dn512++; if (dat512 < 0) dat512 = c; end
      tick();
    end
    checks++;
    if (first256 != 0 || dat256 - first256 != 64 || dn256 != 1) begin
      failures++;
      $display("FAIL done256_timing: first=%0d done_at=%0d pulses=%0d, want first=0 done_at=64 pulses=1",
               first256, dat256, dn256);
    end
    checks++;
    if (first512 != 0 || dat512 - first512 != 80 || dn512 != 1) begin
      failures++;
      $display("FAIL done512_timing: first=%0d done_at=%0d pulses=%0d, want first=0 done_at=80 pulses=1",
               first512, dat512, dn512);
    end
    checks++;
    if (q256.size() != 0 || q512.size() != 0) begin
      failures++;
      $display("FAIL stream_missing: left256=%0d left512=%0d, want 0 0", q256.size(), q512.size());
    end
    checks++;
    if ({done512, v512, busy512, done256, v256} !== '0) begin
      failures++;
      $display("FAIL after_done: done512=%b v512=%b busy512=%b done256=%b v256=%b, want 0",
               done512, v512, busy512, done256, v256);
    end
    $display("test_full_stream complete: done256 at %0d, done512 at %0d", dat256, dat512);
  endtask

  task automatic test_backpressure();
    beat_t e;
    int stalled = 0;
    bit seen_done = 0;
    clean();
    push_stream(0);
    start = 1'b1; k_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 120 && !seen_done; c++) begin
      if (v256 && r256 == 6'd10 && stalled < 5) begin
        k_ready = 1'b0;
        stalled++;
        checks++;
        if (k256 !== 32'h243185be) begin
          failures++;
          $display("FAIL stall_hold: k=%h r=%0d, want k=243185be r=10", k256, r256);
        end
      end else begin
        k_ready = 1'b1;
      end
      if (v256) begin
        checks++;
        if (q256.size() == 0) begin
          failures++;
          $display("FAIL bp_extra: beat r=%0d, want none", r256);
        end else begin
          e = q256[0];
          if (k256 !== e.k[63:32] || r256 !== 6'(e.rnd)) begin
            failures++;
            $display("FAIL bp_beat: k=%h r=%0d, want k=%h r=%0d", k256, r256, e.k[63:32], e.rnd);
          end
          if (k_ready) void'(q256.pop_front());
        end
      end
      if (done256) seen_done = 1;
      tick();
    end
    k_ready = 1'b1;
    checks++;
    if (stalled != 5 || !seen_done || q256.size() != 0) begin
      failures++;
      $display("FAIL bp_summary: stalls=%0d done=%0d left=%0d, want 5 1 0", stalled, seen_done, q256.size());
    end
    $display("test_backpressure complete: %0d stall cycles", stalled);
  endtask

  task automatic test_abort();
    int c;
    clean();
    start = 1'b1; k_ready = 1'b1;
    tick();
    start = 1'b0;
    for (c = 0; c < 100 && !(v256 && r256 == 6'd30); c++) tick();
    checks++;
    if (c >= 100) begin
      failures++;
      $display("FAIL abort_reach30: round_n=%0d, want 30 within 100 cycles", r256);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({v256, busy256, r256, k256, last256, done256, v512, busy512, r512, k512, done512} !== '0) begin
      failures++;
      $display("FAIL abort_clear: v=%b busy=%b r=%0d k=%h done=%b v512=%b r512=%0d, want 0",
               v256, busy256, r256, k256, done256, v512, r512);
    end
    tick();
    checks++;
    if (done256 !== 1'b0 || done512 !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone: done=%b/%b, want 0/0", done256, done512);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (v256 !== 1'b1 || r256 !== 6'd0 || k256 !== 32'h428a2f98 || k512 !== 64'h428a2f98d728ae22) begin
      failures++;
      $display("FAIL abort_restart: v=%b r=%0d k=%h k512=%h, want 1 0 428a2f98 428a2f98d728ae22",
               v256, r256, k256, k512);
    end
    for (c = 0; c < 100 && !(v256 && r256 == 6'd63); c++) tick();
    checks++;
    if (c >= 100 || last256 !== 1'b1 || k256 !== 32'hc67178f2) begin
      failures++;
      $display("FAIL abort_reach63: r=%0d last=%b k=%h, want 63 1 c67178f2", r256, last256, k256);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (done256 !== 1'b0 || v256 !== 1'b0) begin
      failures++;
      $display("FAIL abort_final: done=%b v=%b, want 0 0", done256, v256);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({v256, busy256, v512, busy512} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_start_idle: v=%b busy=%b v512=%b busy512=%b, want 0", v256, busy256, v512, busy512);
    end
    $display("test_abort complete");
  endtask

  task automatic test_back_to_back();
    beat_t e;
    int dones = 0;
    bit after_done = 0;
    start = 1'b0; abort = 1'b0;
    q256.delete();
    rst = 1'b1; start = 1'b1; k_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    push_stream(0);
    for (int c = 0; c < 140; c++) begin
      if (after_done) begin
        checks++;
        if (v256 !== 1'b1 || r256 !== 6'd0) begin
          failures++;
          $display("FAIL b2b_restart: v=%b r=%0d, want v=1 r=0", v256, r256);
        end
        after_done = 0;
      end
      if (v256) begin
        checks++;
        if (q256.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra: beat r=%0d, want none", r256);
        end else begin
          e = q256.pop_front();
          if (k256 !== e.k[63:32] || r256 !== 6'(e.rnd)) begin
            failures++;
            $display("FAIL b2b_beat: k=%h r=%0d, want k=%h r=%0d", k256, r256, e.k[63:32], e.rnd);
          end
        end
      end
      if (done256) begin
        dones++;
        after_done = 1;
        push_stream(0);
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (dones != 2) begin
      failures++;
      $display("FAIL b2b_count: done pulses=%0d, want 2 in 140 cycles", dones);
    end
    $display("test_back_to_back complete: %0d streams", dones);
  endtask

  task automatic test_rst_mid();
    int c;
    clean();
    start = 1'b1; k_ready = 1'b1;
    tick();
    start = 1'b0;
    for (c = 0; c < 100 && !(v256 && r256 == 6'd40); c++) tick();
    checks++;
    if (c >= 100) begin
      failures++;
      $display("FAIL rst_reach40: round_n=%0d, want 40 within 100 cycles", r256);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({v256, k256, r256, last256, busy256, done256, v512, k512, r512, last512, busy512, done512} !== '0) begin
      failures++;
      $display("FAIL rst_mid_clear: v=%b k=%h r=%0d busy=%b done=%b v512=%b r512=%0d, want 0",
               v256, k256, r256, busy256, done256, v512, r512);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({v256, busy256, done256} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid_idle: v=%b busy=%b done=%b, want 0", v256, busy256, done256);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (v256 !== 1'b1 || r256 !== 6'd0 || k256 !== 32'h428a2f98) begin
      failures++;
      $display("FAIL rst_mid_restart: v=%b r=%0d k=%h, want 1 0 428a2f98", v256, r256, k256);
    end
    $display("test_rst_mid complete");
  endtask

  initial begin
    K = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };
    test_reset();
    test_full_stream();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
